// File: rtl/child_slot_rr_scheduler.sv
// Round-robin owner scheduler for one shared resource slot among NUM_REQ child instances.
// Define SLOT_SCHED_STATS_EN to add saturating grant_count / timeout_count outputs.
module child_slot_rr_scheduler #(
    parameter int NUM_REQ  = 5,
    parameter int MAX_HOLD = 16,
    parameter int ID_W     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id,
    output logic               timeout,
    output logic               busy
`ifdef SLOT_SCHED_STATS_EN
    ,
    output logic [15:0]        grant_count,
    output logic [15:0]        timeout_count
`endif
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    typedef struct packed {
        logic [NUM_REQ-1:0] gnt;
        logic [ID_W-1:0]    id;
        logic               timeout;
    } slot_t;

    state_t      state, state_nxt;
    slot_t       cur, nxt;
    logic [ID_W-1:0] ptr, ptr_nxt;
    logic [7:0]  hold_cnt, hold_nxt;
    logic [ID_W-1:0] win_id;
    logic        win_vld;
    logic        release_c;
    logic        at_limit;

    // Rotating priority scan: iterate from lowest priority up so the first
    // set bit at or after ptr is the last one written.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ]) begin
                win_vld = 1'b1;
                win_id  = ID_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    assign release_c = done[cur.id] | ~req[cur.id];
    assign at_limit  = (hold_cnt == 8'(MAX_HOLD));

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        nxt         = cur;
        nxt.timeout = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (win_vld) begin
                    state_nxt       = GRANT;
                    nxt.gnt         = '0;
                    nxt.gnt[win_id] = 1'b1;
                    nxt.id          = win_id;
                    hold_nxt        = 8'd1;
                end else begin
                    state_nxt = IDLE;
                    nxt.gnt   = '0;
                    nxt.id    = '0;
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (release_c || at_limit) begin
                    // A release on the last allowed cycle wins over the revoke.
                    state_nxt   = GAP;
                    nxt.gnt     = '0;
                    nxt.id      = '0;
                    nxt.timeout = ~release_c;
                    hold_nxt    = '0;
                    ptr_nxt     = (cur.id == ID_W'(NUM_REQ - 1)) ? '0 : cur.id + 1'b1;
                end else if (hold_cnt != 8'hFF) begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                nxt.gnt   = '0;
                nxt.id    = '0;
                hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            cur      <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            cur      <= nxt;
        end
    end

    assign gnt       = cur.gnt;
    assign gnt_id    = cur.id;
    assign timeout   = cur.timeout;
    assign gnt_valid = |cur.gnt;
    assign busy      = (state != IDLE);

`ifdef SLOT_SCHED_STATS_EN
    logic grant_entry;
    assign grant_entry = (state != GRANT) && (state_nxt == GRANT);

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_count   <= '0;
            timeout_count <= '0;
        end else begin
            if (grant_entry && grant_count != 16'hFFFF)
                grant_count <= grant_count + 16'd1;
            if (nxt.timeout && timeout_count != 16'hFFFF)
                timeout_count <= timeout_count + 16'd1;
        end
    end
`endif

endmodule
